// File: rtl/mul_issue.sv
`default_nettype none
// ============================================================================
// Module   : mul_issue
// Brief    : Front-end sequencer for the 64x64 iterative multiplier core.
//            Accepts operand pairs on a valid/ready stream, runs one core
//            operation per pair (load, start pulse, wait for done, capture,
//            clear pulse), and returns tagged results through a single-entry
//            output buffer. A watchdog aborts operations that never finish.
// Revision : 1.0 - initial release
// ============================================================================
module mul_issue #(
  parameter int TIMEOUT = 32,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  // request stream
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [63:0]        in_a,
  input  logic [63:0]        in_b,
  input  logic [TAG_W-1:0]   in_tag,
  // multiplier core interface
  output logic [63:0]        core_multiplier,
  output logic [63:0]        core_multiplicand,
  output logic               core_op_start,
  output logic               core_op_clear,
  input  logic               core_op_done,
  input  logic [127:0]       core_result,
  // result buffer
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_result,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err,
  // status
  output logic [15:0]        ops_done,
  output logic               err_seen
);

  // Watchdog only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WD_W-1:0]  wd;
  logic [TAG_W-1:0] req_tag;

  logic accept;
  logic out_take;
  logic wd_expired;
  logic load_ok;
  logic load_timeout;

  // A new request is only taken while idle and when the buffer is free
  // (or being drained in this very cycle).
  assign in_ready     = (state == IDLE) && (!out_valid || out_ready);
  assign accept       = in_valid && in_ready;
  assign out_take     = out_valid && out_ready;
  assign wd_expired   = (wd == WD_LAST);
  // Done wins over the watchdog when both occur in the same cycle.
  assign load_ok      = (state == WAIT) && core_op_done;
  assign load_timeout = (state == WAIT) && !core_op_done && wd_expired;

  // Next-state decode for the operation sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (load_ok || load_timeout) state_next = CLEAR;
      CLEAR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Core control pulses, registered so they coincide exactly with START/CLEAR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_op_start <= 1'b0;
      core_op_clear <= 1'b0;
    end else begin
      core_op_start <= (state_next == START);
      core_op_clear <= (state_next == CLEAR);
    end
  end

  // Operand and tag latch; the core operand outputs come only from here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_multiplier   <= 64'd0;
      core_multiplicand <= 64'd0;
      req_tag           <= '0;
    end else if (accept) begin
      core_multiplier   <= in_a;
      core_multiplicand <= in_b;
      req_tag           <= in_tag;
    end
  end

  // Watchdog: zeroed in START, counts every WAIT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd <= '0;
    end else if (state == START) begin
      wd <= '0;
    end else if (state == WAIT) begin
      wd <= wd + WD_W'(1);
    end
  end

  // Single-entry result buffer; contents only change on a load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_result <= 128'd0;
      out_tag    <= '0;
      out_err    <= 1'b0;
    end else if (load_ok) begin
      out_valid  <= 1'b1;
      out_result <= core_result;
      out_tag    <= req_tag;
      out_err    <= 1'b0;
    end else if (load_timeout) begin
      out_valid  <= 1'b1;
      out_result <= 128'd0;
      out_tag    <= req_tag;
      out_err    <= 1'b1;
    end else if (out_take) begin
      out_valid  <= 1'b0;
    end
  end

  // Completion counter (error-free deliveries only) and sticky timeout flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ops_done <= 16'd0;
      err_seen <= 1'b0;
    end else begin
      if (out_take && !out_err) begin
        ops_done <= ops_done + 16'd1;
      end
      if (load_timeout) begin
        err_seen <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_issue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mul_issue
// Brief    : Self-checking bench for mul_issue with a 16-iteration core model,
//            a queue-based result scoreboard and directed timing sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_issue;

  localparam int TIMEOUT = 32;
  localparam int TAG_W   = 4;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic [63:0]        in_a;
  logic [63:0]        in_b;
  logic [TAG_W-1:0]   in_tag;
  logic [63:0]        core_multiplier;
  logic [63:0]        core_multiplicand;
  logic               core_op_start;
  logic               core_op_clear;
  logic               core_op_done;
  logic [127:0]       core_result;
  logic               out_valid;
  logic               out_ready;
  logic [127:0]       out_result;
  logic [TAG_W-1:0]   out_tag;
  logic               out_err;
  logic [15:0]        ops_done;
  logic               err_seen;

  always #5 clk = ~clk;

  mul_issue #(.TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_a              (in_a),
    .in_b              (in_b),
    .in_tag            (in_tag),
    .core_multiplier   (core_multiplier),
    .core_multiplicand (core_multiplicand),
    .core_op_start     (core_op_start),
    .core_op_clear     (core_op_clear),
    .core_op_done      (core_op_done),
    .core_result       (core_result),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_result        (out_result),
    .out_tag           (out_tag),
    .out_err           (out_err),
    .ops_done          (ops_done),
    .err_seen          (err_seen)
  );

  int vectors    = 0;
  int miscompares = 0;
  int cycle      = 0;

  always @(posedge clk) cycle++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- core model: done first high 16 cycles after the start pulse
  logic         core_stall = 1'b0;
  logic         busy;
  logic         done_r;
  logic [4:0]   cnt;
  logic [127:0] prod;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0; done_r <= 1'b0; cnt <= 5'd0; prod <= 128'd0;
    end else if (core_op_clear) begin
      busy <= 1'b0; done_r <= 1'b0; cnt <= 5'd0;
    end else if (core_op_start) begin
      busy <= 1'b1; done_r <= 1'b0; cnt <= 5'd1;
      prod <= 128'(core_multiplier) * 128'(core_multiplicand);
    end else if (busy && !done_r) begin
      cnt <= cnt + 5'd1;
      if (cnt == 5'd15) done_r <= 1'b1;
    end
  end

  assign core_op_done = done_r & ~core_stall;
  assign core_result  = prod;

  // ---------------- scoreboard: expected results in acceptance order
  typedef struct {
    logic [127:0]     res;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t             q[$];
  exp_t             e;
  logic [15:0]      exp_ops = 16'd0;
  logic             exp_err_seen = 1'b0;
  logic             prev_hold = 1'b0;
  logic [127:0]     prev_res;
  logic [TAG_W-1:0] prev_tag;
  logic             prev_err;

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      exp_ops      = 16'd0;
      exp_err_seen = 1'b0;
      prev_hold    = 1'b0;
    end else begin
      chk("start_clear_overlap", {127'd0, core_op_start & core_op_clear}, 128'd0);
      if (prev_hold) begin
        chk("hold_valid", {127'd0, out_valid}, 128'd1);
        chk("hold_result", out_result, prev_res);
        chk("hold_tag", {{(128-TAG_W){1'b0}}, out_tag}, {{(128-TAG_W){1'b0}}, prev_tag});
        chk("hold_err", {127'd0, out_err}, {127'd0, prev_err});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_unexpected: got result 0x%0h tag %0d, expected none", out_result, out_tag);
        end else begin
          e = q.pop_front();
          chk("sb_result", out_result, e.res);
          chk("sb_tag", {{(128-TAG_W){1'b0}}, out_tag}, {{(128-TAG_W){1'b0}}, e.tag});
          chk("sb_err", {127'd0, out_err}, {127'd0, e.err});
          chk("sb_ops_done", {112'd0, ops_done}, {112'd0, exp_ops});
          if (!e.err) exp_ops = exp_ops + 16'd1;
          exp_err_seen = exp_err_seen | e.err;
          chk("sb_err_seen", {127'd0, err_seen}, {127'd0, exp_err_seen});
        end
      end
      if (in_valid && in_ready) begin
        e.res = core_stall ? 128'd0 : 128'(in_a) * 128'(in_b);
        e.tag = in_tag;
        e.err = core_stall;
        q.push_back(e);
      end
      prev_hold = out_valid && !out_ready;
      prev_res  = out_result;
      prev_tag  = out_tag;
      prev_err  = out_err;
    end
  end

  // Random backpressure when enabled.
  logic rand_rdy = 1'b0;
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- helpers (called at posedge + 1)
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_in_ready"}, {127'd0, in_ready}, 128'd1);
    chk({nm, "_mult"}, {64'd0, core_multiplier}, 128'd0);
    chk({nm, "_mcand"}, {64'd0, core_multiplicand}, 128'd0);
    chk({nm, "_start"}, {127'd0, core_op_start}, 128'd0);
    chk({nm, "_clear"}, {127'd0, core_op_clear}, 128'd0);
    chk({nm, "_out_valid"}, {127'd0, out_valid}, 128'd0);
    chk({nm, "_out_err"}, {127'd0, out_err}, 128'd0);
    chk({nm, "_out_result"}, out_result, 128'd0);
    chk({nm, "_out_tag"}, {{(128-TAG_W){1'b0}}, out_tag}, 128'd0);
    chk({nm, "_ops_done"}, {112'd0, ops_done}, 128'd0);
    chk({nm, "_err_seen"}, {127'd0, err_seen}, 128'd0);
  endtask

  // Present a request and return at accept edge + 1 (i.e. in cycle 1).
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] tag);
    bit ok = 1'b0;
    in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    chk("send_accepted", {127'd0, ok}, 128'd1);
    if (ok) @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Single operation with cycle-exact observation of pulses and result.
  task automatic run_timed(input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] tag,
                           input logic [127:0] exp_res, input logic exp_err, input int exp_vcyc,
                           input logic [15:0] exp_ops_after, input string nm);
    int n_start = 0, n_clear = 0, first_start = -1, first_clear = -1, vcyc = -1;
    logic [127:0]     r = '0;
    logic [TAG_W-1:0] t = '0;
    logic             er = 1'b0;
    send(a, b, tag);
    for (int c = 1; c <= TIMEOUT + 8; c++) begin
      @(negedge clk);
      if (core_op_start) begin n_start++; if (first_start < 0) first_start = c; end
      if (core_op_clear) begin n_clear++; if (first_clear < 0) first_clear = c; end
      if (out_valid && vcyc < 0) begin vcyc = c; r = out_result; t = out_tag; er = out_err; end
      if (vcyc > 0 && c == vcyc + 1)
        chk({nm, "_ops_done"}, {112'd0, ops_done}, {112'd0, exp_ops_after});
      @(posedge clk);
      #1;
    end
    chk({nm, "_start_cycle"}, 128'(first_start), 128'd1);
    chk({nm, "_start_count"}, 128'(n_start), 128'd1);
    chk({nm, "_valid_cycle"}, 128'(vcyc), 128'(exp_vcyc));
    chk({nm, "_clear_cycle"}, 128'(first_clear), 128'(exp_vcyc));
    chk({nm, "_clear_count"}, 128'(n_clear), 128'd1);
    chk({nm, "_result"}, r, exp_res);
    chk({nm, "_tag"}, {{(128-TAG_W){1'b0}}, t}, {{(128-TAG_W){1'b0}}, tag});
    chk({nm, "_err"}, {127'd0, er}, {127'd0, exp_err});
  endtask

  typedef struct {
    logic [63:0]      a;
    logic [63:0]      b;
    logic [TAG_W-1:0] tag;
    logic [127:0]     exp;
  } vec_t;

  vec_t        vecs[7];
  int          acc_cyc[4];
  logic [63:0] ra, rb;

  initial begin
    vecs[0] = '{64'd3, 64'd5, 4'd7, 128'd15};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1,
                128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
    vecs[2] = '{64'd0, 64'h1234, 4'd2, 128'd0};
    vecs[3] = '{64'd1, 64'hDEAD_BEEF_CAFE_BABE, 4'd3, 128'hDEAD_BEEF_CAFE_BABE};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'd2, 4'd4, 128'h1_0000_0000_0000_0000};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'd5, 128'h1_FFFF_FFFF_FFFF_FFFE};
    vecs[6] = '{64'h1_0000, 64'h1_0000, 4'd15, 128'h1_0000_0000};

    reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Table: one op at a time, full timing checks; counter climbs by one each.
    for (int i = 0; i < 7; i++)
      run_timed(vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp, 1'b0, 18, 16'(i + 1), "vec");

    // Timeout with a stalled core.
    core_stall = 1'b1;
    run_timed(64'd9, 64'd9, 4'd9, 128'd0, 1'b1, TIMEOUT + 2, 16'd7, "timeout");
    chk("timeout_err_seen", {127'd0, err_seen}, 128'd1);
    core_stall = 1'b0;

    // Reset in the middle of WAIT.
    send(64'd11, 64'd13, 4'd6);
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("midrst_no_valid", 128'(seen), 128'd0);
    end
    @(posedge clk); #1;
    run_timed(64'd21, 64'd4, 4'd10, 128'd84, 1'b0, 18, 16'd1, "after_rst");

    // Back-to-back with in_valid held high.
    do_reset();
    begin
      int k = 0;
      int acc = 0;
      in_a = 64'd1000; in_b = 64'd3; in_tag = 4'd0; in_valid = 1'b1;
      for (int c = 0; c < 200 && k < 4; c++) begin
        @(negedge clk);
        if (in_ready) begin
          acc = cycle;
          @(posedge clk); #1;
          acc_cyc[k] = acc;
          k++;
          in_a = 64'd1000 + 64'(k * 7); in_b = 64'd3 + 64'(k * 11); in_tag = 4'(k);
          if (k == 4) in_valid = 1'b0;
        end else begin
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b0;
      chk("b2b_accepts", 128'(k), 128'd4);
      for (int j = 1; j < 4; j++)
        chk("b2b_gap", 128'(acc_cyc[j] - acc_cyc[j-1]), 128'd19);
      repeat (30) @(posedge clk);
      #1;
      chk("b2b_ops_done", {112'd0, ops_done}, 128'd4);
      chk("b2b_drained", 128'(q.size()), 128'd0);
    end

    // Backpressure: result held, drain and new accept on the same edge.
    do_reset();
    out_ready = 1'b0;
    send(64'd6, 64'd7, 4'd12);
    in_a = 64'd100; in_b = 64'd200; in_tag = 4'd13; in_valid = 1'b1;
    begin
      bit found = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (out_valid) begin found = 1'b1; break; end
      end
      chk("bp_valid_seen", {127'd0, found}, 128'd1);
      for (int c = 0; c < 5; c++) begin
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
        chk("bp_result", out_result, 128'd42);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_drain", {127'd0, in_ready}, 128'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_valid_cleared", {127'd0, out_valid}, 128'd0);
      chk("bp_second_started", {127'd0, core_op_start}, 128'd1);
      repeat (30) @(posedge clk);
      #1;
      chk("bp_ops_done", {112'd0, ops_done}, 128'd2);
      chk("bp_drained", 128'(q.size()), 128'd0);
    end

    // Random operands, random stalls and backpressure against the scoreboard.
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      core_stall = ($urandom_range(0, 7) == 0);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 10 == 3) ra = '1;
      if (i % 10 == 4) rb = '1;
      send(ra, rb, 4'(i));
      for (int w = 0; w < 200 && q.size() != 0; w++) @(posedge clk);
      #1;
      chk("rand_drained", 128'(q.size()), 128'd0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rand_rdy = 1'b0;
    core_stall = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
